sample_voice_engine: RTL and testbench

- Parametrised multi-voice sample playback engine; successor to the single 8051-driven DAC port on the sound MCU.
- The host (MCU emulator or Z80-side logic) issues per-voice commands: START (address), STOP, VOLUME, RATE.
- The engine fetches 8-bit unsigned samples from the shared sample ROM at per-voice rates, honours the 0x00 end-of-sample marker, and mixes all voices into one saturated unsigned output.

---
 rtl/sample_voice_pkg.sv | 28 ++
 rtl/sample_voice_mixer.sv | 64 ++++++
 rtl/sample_voice_engine.sv | 204 ++++++++++++++++++++
 tb/tb_sample_voice_engine.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_voice_pkg.sv
// Shared types and constants for the multi-voice sample playback engine.
package sample_voice_pkg;

  // Host command opcodes carried on cmd_op.
  typedef enum logic [1:0] {
    OP_START  = 2'd0,
    OP_STOP   = 2'd1,
    OP_VOLUME = 2'd2,
    OP_RATE   = 2'd3
  } cmd_op_e;

  // ROM fetch sequencer: strobe, wait one cycle, capture.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_CAPTURE = 2'd2
  } fetch_state_e;

  localparam logic [7:0] END_MARKER = 8'h00;
  localparam logic [7:0] SILENCE    = 8'h80;
  localparam logic [3:0] VOLUME_MAX = 4'd15;

  // Width of a voice index; a single-voice build still gets a 1-bit select.
  function automatic int chan_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/sample_voice_mixer.sv
// Sums the held voice samples scaled by volume, scales to OUT_W and
// saturates, registering the result on each clock enable.
module sample_voice_mixer
  import sample_voice_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int OUT_W    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [CHANNELS*8-1:0] samples,
  input  logic [CHANNELS*4-1:0] volumes,
  output logic [OUT_W-1:0]      mix_out
);

  localparam int ACC_W = 12 + $clog2(CHANNELS);
  localparam int SHIFT = 12 - OUT_W;
  localparam logic signed [ACC_W-1:0] MIX_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MIX_MIN = ~MIX_MAX;
  localparam logic [OUT_W-1:0] MID_SCALE = {1'b1, {(OUT_W - 1){1'b0}}};

  logic signed [13:0]      term [CHANNELS];
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] mix;
  logic signed [ACC_W-1:0] sat;
  logic [OUT_W-1:0]        mix_next;

  // Per voice: re-centre the unsigned sample around silence and apply gain.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_term
    logic signed [8:0] centred;
    logic signed [4:0] gain;
    assign centred  = $signed({1'b0, samples[gi*8 +: 8]}) - $signed({1'b0, SILENCE});
    assign gain     = $signed({1'b0, volumes[gi*4 +: 4]});
    assign term[gi] = 14'(centred) * 14'(gain);
  end

  // Accumulate, scale down and clamp to the signed output range.
  always_comb begin
    acc = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      acc = acc + ACC_W'(term[i]);
    end
    mix = acc >>> SHIFT;
    sat = mix;
    if (mix > MIX_MAX) begin
      sat = MIX_MAX;
    end else if (mix < MIX_MIN) begin
      sat = MIX_MIN;
    end
    // Adding half scale to a two's complement value is an MSB flip.
    mix_next = {~sat[OUT_W-1], sat[OUT_W-2:0]};
  end

  // Output register updates only on the sample-rate enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mix_out <= MID_SCALE;
    end else if (ce) begin
      mix_out <= mix_next;
    end
  end

endmodule

// File: rtl/sample_voice_engine.sv
// Multi-voice sample playback: per-voice rate dividers, a shared ROM fetch
// sequencer that round-robins over voices, and a saturating mixer.
module sample_voice_engine
  import sample_voice_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = 18,
  parameter int OUT_W    = 10,
  parameter int RATE_W   = 8
) (
  input  logic                             CLK_32M,
  input  logic                             reset,
  input  logic                             ce_8m,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [chan_width(CHANNELS)-1:0]  cmd_chan,
  input  logic [1:0]                       cmd_op,
  input  logic [ADDR_W-1:0]                cmd_addr,
  input  logic [RATE_W-1:0]                cmd_data,
  output logic [ADDR_W-1:0]                rom_addr,
  output logic                             rom_cs,
  input  logic [7:0]                       rom_data,
  output logic [CHANNELS-1:0]              busy,
  output logic [CHANNELS-1:0]              done,
  output logic [OUT_W-1:0]                 sample_out
);

  localparam int CHAN_W = chan_width(CHANNELS);
  // A voice cannot be serviced more often than the scan visits it.
  localparam logic [RATE_W-1:0] RATE_MIN  = RATE_W'(CHANNELS - 1);
  localparam logic [CHAN_W-1:0] SCAN_LAST = CHAN_W'(CHANNELS - 1);

  fetch_state_e        state_reg, state_next;
  logic [CHAN_W-1:0]   scan_reg;
  logic [CHAN_W-1:0]   fetch_chan_reg;
  logic [ADDR_W-1:0]   rom_addr_reg, rom_addr_next;
  logic                rom_cs_reg, rom_cs_next;
  logic                cmd_ready_reg;
  logic                cmd_fire;
  logic                cmd_hits_scan;
  logic                launch;
  logic                capture;
  cmd_op_e             op;

  logic [CHANNELS-1:0]   busy_vec;
  logic [CHANNELS-1:0]   pending_vec;
  logic [CHANNELS-1:0]   done_vec;
  logic [ADDR_W-1:0]     voice_addr [CHANNELS];
  logic [CHANNELS*8-1:0] sample_flat;
  logic [CHANNELS*4-1:0] volume_flat;

  assign cmd_fire      = cmd_valid & cmd_ready_reg;
  assign op            = cmd_op_e'(cmd_op);
  assign capture       = (state_reg == ST_CAPTURE);
  // A command landing on the voice about to be fetched takes priority;
  // the fetch is retried on that voice's next scan slot.
  assign cmd_hits_scan = cmd_fire && (cmd_chan == scan_reg);

  // Fetch sequencer next-state and ROM strobe decode.
  always_comb begin
    state_next    = state_reg;
    rom_cs_next   = 1'b0;
    rom_addr_next = rom_addr_reg;
    launch        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (ce_8m && busy_vec[scan_reg] && pending_vec[scan_reg] && !cmd_hits_scan) begin
          launch        = 1'b1;
          rom_cs_next   = 1'b1;
          rom_addr_next = voice_addr[scan_reg];
          state_next    = ST_READ;
        end
      end
      ST_READ:    state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Sequencer state, registered ROM interface and command handshake.
  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      rom_cs_reg     <= 1'b0;
      rom_addr_reg   <= '0;
      cmd_ready_reg  <= 1'b0;
      fetch_chan_reg <= '0;
    end else begin
      state_reg     <= state_next;
      rom_cs_reg    <= rom_cs_next;
      rom_addr_reg  <= rom_addr_next;
      cmd_ready_reg <= (state_next == ST_IDLE);
      if (launch) begin
        fetch_chan_reg <= scan_reg;
      end
    end
  end

  // Round-robin scan pointer, advancing on every enable.
  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      scan_reg <= '0;
    end else if (ce_8m) begin
      scan_reg <= (scan_reg == SCAN_LAST) ? '0 : scan_reg + CHAN_W'(1);
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_voice
    logic [ADDR_W-1:0] addr_reg;
    logic [RATE_W-1:0] rate_reg;
    logic [RATE_W-1:0] count_reg;
    logic [7:0]        sample_reg;
    logic [3:0]        volume_reg;
    logic              busy_reg;
    logic              pending_reg;
    logic              done_reg;
    logic              cmd_hit;
    logic              cap_hit;

    assign cmd_hit = cmd_fire && (cmd_chan == CHAN_W'(gi));
    assign cap_hit = capture && busy_reg && (fetch_chan_reg == CHAN_W'(gi));

    // Voice state: divider, capture of fetched data, then host commands last
    // so a command always wins over same-edge housekeeping.
    always_ff @(posedge CLK_32M or posedge reset) begin
      if (reset) begin
        addr_reg    <= '0;
        rate_reg    <= RATE_MIN;
        count_reg   <= RATE_MIN;
        sample_reg  <= SILENCE;
        volume_reg  <= VOLUME_MAX;
        busy_reg    <= 1'b0;
        pending_reg <= 1'b0;
        done_reg    <= 1'b0;
      end else begin
        done_reg <= 1'b0;
        if (ce_8m && busy_reg) begin
          if (count_reg == '0) begin
            count_reg   <= rate_reg;
            pending_reg <= 1'b1;
          end else begin
            count_reg <= count_reg - RATE_W'(1);
          end
        end
        if (cap_hit) begin
          pending_reg <= 1'b0;
          if (rom_data == END_MARKER) begin
            busy_reg   <= 1'b0;
            sample_reg <= SILENCE;
            done_reg   <= 1'b1;
          end else begin
            sample_reg <= rom_data;
            addr_reg   <= addr_reg + ADDR_W'(1);
          end
        end
        if (cmd_hit) begin
          case (op)
            OP_START: begin
              addr_reg    <= cmd_addr;
              busy_reg    <= 1'b1;
              pending_reg <= 1'b0;
              count_reg   <= rate_reg;
              sample_reg  <= SILENCE;
            end
            OP_STOP: begin
              busy_reg    <= 1'b0;
              pending_reg <= 1'b0;
              sample_reg  <= SILENCE;
            end
            OP_VOLUME: volume_reg <= cmd_data[3:0];
            OP_RATE:   rate_reg   <= (cmd_data < RATE_MIN) ? RATE_MIN : cmd_data;
            default: ;
          endcase
        end
      end
    end

    assign busy_vec[gi]            = busy_reg;
    assign pending_vec[gi]         = pending_reg;
    assign done_vec[gi]            = done_reg;
    assign voice_addr[gi]          = addr_reg;
    assign sample_flat[gi*8 +: 8]  = sample_reg;
    assign volume_flat[gi*4 +: 4]  = volume_reg;
  end

  sample_voice_mixer #(
    .CHANNELS (CHANNELS),
    .OUT_W    (OUT_W)
  ) u_mixer (
    .clk     (CLK_32M),
    .rst     (reset),
    .ce      (ce_8m),
    .samples (sample_flat),
    .volumes (volume_flat),
    .mix_out (sample_out)
  );

  assign cmd_ready = cmd_ready_reg;
  assign rom_cs    = rom_cs_reg;
  assign rom_addr  = rom_addr_reg;
  assign busy      = busy_vec;
  assign done      = done_vec;

endmodule

// File: tb/tb_sample_voice_engine.sv
// Directed bench for sample_voice_engine with a one-cycle-latency ROM model.
module tb_sample_voice_engine;
  import sample_voice_pkg::*;

  localparam int CHANNELS = 4;
  localparam int ADDR_W   = 18;
  localparam int OUT_W    = 10;
  localparam int RATE_W   = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ce_8m = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_chan = 2'd0;
  logic [1:0]        cmd_op = 2'd0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [RATE_W-1:0] cmd_data = '0;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_cs;
  logic [7:0]        rom_data = 8'hEE;
  logic [CHANNELS-1:0] busy;
  logic [CHANNELS-1:0] done;
  logic [OUT_W-1:0]  sample_out;

  int total = 0;
  int bad = 0;
  int done_cnt [CHANNELS];
  logic [7:0] rom_mem [int];

  sample_voice_engine #(
    .CHANNELS (CHANNELS),
    .ADDR_W   (ADDR_W),
    .OUT_W    (OUT_W),
    .RATE_W   (RATE_W)
  ) dut (
    .CLK_32M    (clk),
    .reset      (reset),
    .ce_8m      (ce_8m),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_chan   (cmd_chan),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .rom_addr   (rom_addr),
    .rom_cs     (rom_cs),
    .rom_data   (rom_data),
    .busy       (busy),
    .done       (done),
    .sample_out (sample_out)
  );

  always #5 clk = ~clk;

  // Clock enable: one cycle in four, changed on the falling edge.
  initial begin
    int phase;
    phase = 0;
    forever begin
      @(negedge clk);
      ce_8m = (phase == 3);
      phase = (phase + 1) % 4;
    end
  end

  function automatic logic [7:0] rom_read(input logic [ADDR_W-1:0] a);
    if (rom_mem.exists(int'(a))) return rom_mem[int'(a)];
    return 8'h00;
  endfunction

  // ROM answers one clock after the strobe.
  always @(posedge clk) begin
    if (rom_cs) rom_data <= rom_read(rom_addr);
  end

  // Count done pulses per voice.
  always @(negedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (done[i]) done_cnt[i]++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next clock edge that carried ce_8m.
  task automatic tick_ce();
    do @(posedge clk); while (!ce_8m);
    #1;
  endtask

  task automatic send_cmd(input int chan, input logic [1:0] op,
                          input logic [ADDR_W-1:0] addr, input logic [7:0] data);
    int waited;
    waited = 0;
    cmd_chan  = chan[1:0];
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_valid = 1'b1;
    @(posedge clk);
    while (!cmd_ready && waited < 20) begin
      waited++;
      @(posedge clk);
    end
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL cmd_accept: cmd_ready got 0 expected 1 within 20 cycles");
    end
    #1 cmd_valid = 1'b0;
    $display("cmd chan=%0d op=%0d addr=%05h data=%02h", chan, op, addr, data);
  endtask

  // Returns after the falling edge at which a fetch inside [lo,hi] is strobed.
  task automatic wait_launch(input int lo, input int hi);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rom_cs && int'(rom_addr) >= lo && int'(rom_addr) <= hi) && n < 200);
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL launch_timeout: no fetch in %0h..%0h within 200 cycles", lo, hi);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 4'h0) begin bad++; $display("FAIL reset_busy: got %h expected 0", busy); end
    total++; if (done !== 4'h0) begin bad++; $display("FAIL reset_done: got %h expected 0", done); end
    total++; if (rom_cs !== 1'b0) begin bad++; $display("FAIL reset_rom_cs: got %b expected 0", rom_cs); end
    total++; if (rom_addr !== '0) begin bad++; $display("FAIL reset_rom_addr: got %h expected 0", rom_addr); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready); end
    total++; if (sample_out !== 10'd512) begin bad++; $display("FAIL reset_sample_out: got %0d expected 512", sample_out); end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL idle_cmd_ready: got %b expected 1", cmd_ready); end
    $display("reset checked sample_out=%0d", sample_out);
  endtask

  task automatic test_playback();
    logic [9:0] seq [$];
    logic [9:0] last;
    logic [9:0] exp_seq [3];
    int d0;
    exp_seq[0] = 10'd988;  // 0xFF: 127*15=1905 >>>2 = 476, +512
    exp_seq[1] = 10'd182;  // 0x28: -88*15=-1320 >>>2 = -330, +512
    exp_seq[2] = 10'd512;  // end marker returns to silence
    d0 = done_cnt[0];
    send_cmd(0, OP_START, 18'h00100, 8'h00);
    last = sample_out;
    for (int i = 0; i < 40; i++) begin
      tick_ce();
      if (sample_out !== last) begin
        seq.push_back(sample_out);
        last = sample_out;
      end
    end
    total++; if (seq.size() != 3) begin bad++; $display("FAIL play_len: got %0d changes expected 3", seq.size()); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= seq.size()) begin
        bad++; $display("FAIL play_seq%0d: got none expected %0d", i, exp_seq[i]);
      end else if (seq[i] !== exp_seq[i]) begin
        bad++; $display("FAIL play_seq%0d: got %0d expected %0d", i, seq[i], exp_seq[i]);
      end
    end
    total++; if (done_cnt[0] - d0 != 1) begin bad++; $display("FAIL play_done: got %0d pulses expected 1", done_cnt[0] - d0); end
    total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL play_busy: got %b expected 0", busy[0]); end
    $display("playback checked changes=%0d", seq.size());
  endtask

  task automatic test_rate();
    int cnt;
    send_cmd(1, OP_RATE, '0, 8'd9);
    send_cmd(1, OP_START, 18'h02000, 8'h00);
    wait_launch(32'h2000, 32'h2FFF);
    cnt = 0;
    for (int i = 0; i < 320; i++) begin
      @(negedge clk);
      if (rom_cs && rom_addr >= 18'h02000 && rom_addr <= 18'h02FFF) cnt++;
    end
    total++; if (cnt != 8) begin bad++; $display("FAIL rate9_fetches: got %0d expected 8 in 80 ticks", cnt); end
    send_cmd(1, OP_STOP, '0, 8'h00);
    send_cmd(1, OP_RATE, '0, 8'd0);
    send_cmd(1, OP_START, 18'h02000, 8'h00);
    wait_launch(32'h2000, 32'h2FFF);
    cnt = 0;
    for (int i = 0; i < 320; i++) begin
      @(negedge clk);
      if (rom_cs && rom_addr >= 18'h02000 && rom_addr <= 18'h02FFF) cnt++;
    end
    total++; if (cnt != 20) begin bad++; $display("FAIL rate0_fetches: got %0d expected 20 in 80 ticks", cnt); end
    send_cmd(1, OP_STOP, '0, 8'h00);
    $display("rate checked");
  endtask

  task automatic test_saturation();
    for (int v = 0; v < 4; v++) send_cmd(v, OP_START, ADDR_W'(32'h4000 + v * 32'h1000), 8'h00);
    repeat (16) tick_ce();
    total++; if (busy !== 4'hF) begin bad++; $display("FAIL sat_busy: got %h expected f", busy); end
    total++; if (sample_out !== 10'd1023) begin bad++; $display("FAIL sat_high: got %0d expected 1023", sample_out); end
    for (int v = 1; v < 4; v++) send_cmd(v, OP_STOP, '0, 8'h00);
    send_cmd(0, OP_VOLUME, '0, 8'h04);
    repeat (2) tick_ce();
    // 127*4=508 >>>2 = 127, +512
    total++; if (sample_out !== 10'd639) begin bad++; $display("FAIL volume4: got %0d expected 639", sample_out); end
    send_cmd(0, OP_VOLUME, '0, 8'h0F);
    send_cmd(0, OP_STOP, '0, 8'h00);
    for (int v = 0; v < 4; v++) send_cmd(v, OP_START, ADDR_W'(32'h8000 + v * 32'h100), 8'h00);
    repeat (16) tick_ce();
    total++; if (sample_out !== 10'd0) begin bad++; $display("FAIL sat_low: got %0d expected 0", sample_out); end
    for (int v = 0; v < 4; v++) send_cmd(v, OP_STOP, '0, 8'h00);
    repeat (2) tick_ce();
    total++; if (sample_out !== 10'd512) begin bad++; $display("FAIL all_stopped: got %0d expected 512", sample_out); end
    $display("saturation checked");
  endtask

  task automatic test_wrap();
    logic [9:0] seq [$];
    logic [9:0] last;
    send_cmd(0, OP_START, 18'h3FFFF, 8'h00);
    last = sample_out;
    for (int i = 0; i < 20; i++) begin
      tick_ce();
      if (sample_out !== last) begin
        seq.push_back(sample_out);
        last = sample_out;
      end
    end
    // 0x55: -43*15=-645 >>>2 = -162 -> 350; 0x66: -26*15=-390 >>>2 = -98 -> 414
    total++;
    if (seq.size() < 1 || seq[0] !== 10'd350) begin
      bad++; $display("FAIL wrap_first: got %0d expected 350", (seq.size() > 0) ? seq[0] : 10'd0);
    end
    total++;
    if (seq.size() < 2 || seq[1] !== 10'd414) begin
      bad++; $display("FAIL wrap_second: got %0d expected 414", (seq.size() > 1) ? seq[1] : 10'd0);
    end
    total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL wrap_busy: got %b expected 1", busy[0]); end
    send_cmd(0, OP_STOP, '0, 8'h00);
    $display("wrap checked changes=%0d", seq.size());
  endtask

  task automatic test_stop_during_read();
    int d0;
    int waited;
    tick_ce();
    d0 = done_cnt[0];
    send_cmd(0, OP_START, 18'h09000, 8'h00);
    wait_launch(32'h9000, 32'h90FF);
    tick_ce();
    // 0xC0: 64*15=960 >>>2 = 240, +512
    total++; if (sample_out !== 10'd752) begin bad++; $display("FAIL stop_pre_sample: got %0d expected 752", sample_out); end
    wait_launch(32'h9000, 32'h90FF);
    cmd_chan = 2'd0; cmd_op = OP_STOP; cmd_addr = '0; cmd_data = '0; cmd_valid = 1'b1;
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL ready_in_read: got %b expected 0", cmd_ready); end
    @(negedge clk);
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL ready_in_capture: got %b expected 0", cmd_ready); end
    waited = 0;
    @(posedge clk);
    while (!cmd_ready && waited < 20) begin waited++; @(posedge clk); end
    total++; if (!cmd_ready) begin bad++; $display("FAIL stop_accept: cmd_ready got 0 expected 1"); end
    #1 cmd_valid = 1'b0;
    $display("cmd chan=0 op=%0d (held through fetch)", OP_STOP);
    tick_ce();
    total++; if (sample_out !== 10'd512) begin bad++; $display("FAIL stop_sample: got %0d expected 512", sample_out); end
    total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL stop_busy: got %b expected 0", busy[0]); end
    total++; if (done_cnt[0] != d0) begin bad++; $display("FAIL stop_done: got %0d pulses expected 0", done_cnt[0] - d0); end
    $display("stop during read checked");
  endtask

  task automatic test_reset_mid_fetch();
    int d0;
    int cnt;
    send_cmd(0, OP_START, 18'h09000, 8'h00);
    wait_launch(32'h9000, 32'h90FF);
    tick_ce();
    wait_launch(32'h9000, 32'h90FF);
    d0 = done_cnt[0];
    rom_data = 8'h00;  // stale end marker that must never be consumed
    #2 reset = 1'b1;
    #1;
    total++; if (rom_cs !== 1'b0) begin bad++; $display("FAIL async_rom_cs: got %b expected 0", rom_cs); end
    total++; if (rom_addr !== '0) begin bad++; $display("FAIL async_rom_addr: got %h expected 0", rom_addr); end
    total++; if (busy !== 4'h0) begin bad++; $display("FAIL async_busy: got %h expected 0", busy); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL async_cmd_ready: got %b expected 0", cmd_ready); end
    total++; if (sample_out !== 10'd512) begin bad++; $display("FAIL async_sample_out: got %0d expected 512", sample_out); end
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rom_cs) cnt++;
    end
    total++; if (cnt != 0) begin bad++; $display("FAIL post_reset_fetches: got %0d expected 0", cnt); end
    total++; if (done_cnt[0] != d0) begin bad++; $display("FAIL post_reset_done: got %0d pulses expected 0", done_cnt[0] - d0); end
    total++; if (sample_out !== 10'd512) begin bad++; $display("FAIL post_reset_sample: got %0d expected 512", sample_out); end
    $display("reset mid fetch checked");
  endtask

  initial begin
    rom_mem[32'h100] = 8'hFF;
    rom_mem[32'h101] = 8'h28;
    rom_mem[32'h102] = 8'h00;
    for (int i = 0; i < 256; i++) rom_mem[32'h2000 + i] = 8'h90;
    for (int i = 0; i < 256; i++) rom_mem[32'h9000 + i] = 8'hC0;
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 64; i++) begin
        rom_mem[32'h4000 + v * 32'h1000 + i] = 8'hFF;
        rom_mem[32'h8000 + v * 32'h100 + i]  = 8'h01;
      end
    end
    rom_mem[32'h3FFFF] = 8'h55;
    rom_mem[0] = 8'h66;
    rom_mem[1] = 8'h77;
    for (int i = 2; i < 16; i++) rom_mem[i] = 8'h30;

    test_reset();
    test_playback();
    test_rate();
    test_saturation();
    test_wrap();
    test_stop_during_read();
    test_reset_mid_fetch();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
